// File: rtl/top_down_counter.sv
// -----------------------------------------------------------------------------
// top_down_counter
//   Board-level 4-bit down counter with a loadable start value, run/pause
//   control and optional auto-reload. A free-running prescaler produces one
//   count tick every 2^DIV_BITS clocks while the counter is active.
//
// Ports
//   init_clk  in   1   only clock, all state updates on its rising edge
//   reset     in   1   asynchronous, active-low
//   SW        in  10   switches (async): [3:0] load value, [4] load strobe,
//                      [5] run, [6] auto-reload, [9:7] unused
//   LED       out 10   [3:0] count, [4] DONE, [5] RUN, [9:6] reload register
// -----------------------------------------------------------------------------
module top_down_counter #(
  parameter int DIV_BITS = 25
) (
  input  logic       init_clk,
  input  logic       reset,
  input  logic [9:0] SW,
  output logic [9:0] LED
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          count, count_nxt;
  logic [3:0]          reload, reload_nxt;
  logic [DIV_BITS-1:0] presc, presc_nxt;

  logic [6:0] sw_p0, sw_p1;
  logic       ld_p2;
  logic       smp_vld;
  logic       ld_armed;

  logic       load_pulse;
  logic       run_s;
  logic       auto_s;
  logic [3:0] ld_val;
  logic       tick;

  logic       unused_sw;
  assign unused_sw = ^SW[9:7];

  // Stage p0/p1: two-flop synchronizer; p2: extra flop on the strobe for
  // rising-edge detection.
  // ld_armed only sets once a genuine post-reset sample of the strobe has
  // been seen low, so a strobe held high through reset release cannot
  // masquerade as a rising edge against the reset-zero flops.
  always_ff @(posedge init_clk or negedge reset) begin
    if (!reset) begin
      sw_p0    <= '0;
      sw_p1    <= '0;
      ld_p2    <= 1'b0;
      smp_vld  <= 1'b0;
      ld_armed <= 1'b0;
    end else begin
      sw_p0    <= SW[6:0];
      sw_p1    <= sw_p0;
      ld_p2    <= sw_p1[4];
      smp_vld  <= 1'b1;
      ld_armed <= ld_armed | (smp_vld & ~sw_p0[4]);
    end
  end

  assign load_pulse = ld_armed & sw_p1[4] & ~ld_p2;
  assign run_s      = sw_p1[5];
  assign auto_s     = sw_p1[6];
  assign ld_val     = sw_p1[3:0];
  assign tick       = &presc;

  // State register (FSM state plus the count, reload and prescaler it owns)
  always_ff @(posedge init_clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      presc  <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      presc  <= presc_nxt;
    end
  end

  // Next-state logic. A load pulse overrides everything else that cycle,
  // including a coincident tick; run=0 overrides a coincident tick in RUN.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    presc_nxt  = presc + DIV_BITS'(1);
    if (load_pulse) begin
      count_nxt  = ld_val;
      reload_nxt = ld_val;
      presc_nxt  = '0;
      if (state == DONE) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Holding the prescaler at 0 here makes every IDLE->RUN entry
          // (including resume after pause) wait a full period for its tick.
          presc_nxt = '0;
          if (run_s) state_nxt = (count != 4'd0) ? RUN : DONE;
        end
        RUN: begin
          if (!run_s) begin
            state_nxt = IDLE;
          end else if (tick) begin
            // A count of 0 can reach RUN via a load of 0; never wrap.
            if (count <= 4'd1) begin
              count_nxt = 4'd0;
              state_nxt = DONE;
            end else begin
              count_nxt = count - 4'd1;
            end
          end
        end
        DONE: begin
          if (!run_s) begin
            state_nxt = IDLE;
          end else if (auto_s && tick && (reload != 4'd0)) begin
            count_nxt = reload;
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
          presc_nxt = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; SW never reaches LED combinationally.
  always_comb begin
    LED = {reload, (state == RUN), (state == DONE), count};
  end

endmodule

// File: tb/tb_top_down_counter.sv
module tb_top_down_counter;

  localparam int DIV = 2;
  localparam int P   = 1 << DIV;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic       init_clk = 1'b0;
  logic       reset    = 1'b0;
  logic [9:0] SW       = '0;
  logic [9:0] LED;

  top_down_counter #(.DIV_BITS(DIV)) dut (
    .init_clk (init_clk),
    .reset    (reset),
    .SW       (SW),
    .LED      (LED)
  );

  always #5 init_clk = ~init_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: switch history as a queue of raw samples; the counter
  // acts on the sample taken two clocks earlier, and a load is a 0->1 step
  // between two genuine post-reset samples. The timebase is a plain elapsed
  // clock count since the last restart.
  // ---------------------------------------------------------------------------
  int         m_st, m_cnt, m_rel, m_phase;
  logic [9:0] sw_q[$];
  logic [9:0] m_syn;
  bit         m_pulse, m_tick;

  always @(posedge init_clk or negedge reset) begin
    if (!reset) begin
      m_st = M_IDLE; m_cnt = 0; m_rel = 0; m_phase = 0;
      sw_q.delete();
    end else begin
      m_syn   = (sw_q.size() >= 2) ? sw_q[1] : 10'd0;
      m_pulse = (sw_q.size() >= 3) && sw_q[1][4] && !sw_q[2][4];
      m_tick  = (m_phase % P) == (P - 1);
      if (m_pulse) begin
        m_cnt = int'(m_syn[3:0]);
        m_rel = m_cnt;
        m_phase = 0;
        if (m_st == M_DONE) m_st = M_IDLE;
      end else if (m_st == M_IDLE) begin
        m_phase = 0;
        if (m_syn[5]) m_st = (m_cnt > 0) ? M_RUN : M_DONE;
      end else if (m_st == M_RUN) begin
        m_phase++;
        if (!m_syn[5]) m_st = M_IDLE;
        else if (m_tick) begin
          m_cnt = (m_cnt > 1) ? m_cnt - 1 : 0;
          if (m_cnt == 0) m_st = M_DONE;
        end
      end else begin
        m_phase++;
        if (!m_syn[5]) m_st = M_IDLE;
        else if (m_syn[6] && m_tick && m_rel != 0) begin
          m_cnt = m_rel;
          m_st  = M_RUN;
        end
      end
      sw_q.push_front(SW);
      if (sw_q.size() > 3) void'(sw_q.pop_back());
    end
  end

  function automatic logic [9:0] model_led();
    logic [3:0] c, r;
    c = 4'(m_cnt);
    r = 4'(m_rel);
    return {r, (m_st == M_RUN), (m_st == M_DONE), c};
  endfunction

  always @(negedge init_clk) check("led_vs_model", LED, model_led());

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge init_clk);
  endtask

  task automatic wait_val(input logic [3:0] v, input int budget, output int el);
    el = 0;
    while (LED[3:0] !== v && el < budget) begin
      @(negedge init_clk);
      el++;
    end
    check("wait_count_reached", LED[3:0], v);
  endtask

  initial begin
    int el;
    int hold;
    logic [9:0] r;

    // Reset state
    reset = 1'b0; SW = '0;
    cyc(3);
    check("reset_led", LED, 10'd0);
    reset = 1'b1;
    cyc(4);

    // Load 5, run, no auto-reload: 5,4,3,2,1,0 every 4 clocks, then DONE
    SW = 10'h015; cyc(3);
    check("load5_cnt", LED[3:0], 4'd5);
    check("load5_rel", LED[9:6], 4'd5);
    check("load5_idle", LED[5:4], 2'b00);
    SW = 10'h025;
    wait_val(4'd4, 20, el);
    check("first_dec_latency", el, 7);
    for (int v = 3; v >= 0; v--) begin
      wait_val(4'(v), 20, el);
      check("step_period", el, 4);
    end
    check("done_flags", LED[5:4], 2'b01);
    check("done_rel", LED[9:6], 4'b0101);

    // Auto-reload: one DONE tick later count is back at 5 and running
    SW = 10'h065;
    wait_val(4'd5, 20, el);
    check("autoreload_delay", el, 4);
    check("autoreload_run", LED[5:4], 2'b10);
    wait_val(4'd0, 40, el);
    check("auto_countdown_len", el, 20);
    wait_val(4'd5, 20, el);
    check("autoreload_again", el, 4);
    SW = 10'h005; cyc(4);
    check("stop_to_idle", LED[5:4], 2'b00);

    // Pause at 7 and resume: next decrement a full period after re-entry
    SW = 10'h019; cyc(3);
    SW = 10'h029;
    wait_val(4'd7, 40, el);
    check("reach7", el, 11);
    SW = 10'h009; cyc(10);
    check("pause_hold", LED[3:0], 4'd7);
    check("pause_not_run", LED[5], 1'b0);
    SW = 10'h029;
    wait_val(4'd6, 20, el);
    check("resume_latency", el, 7);

    // Load 3 landing on a tick cycle at count 6: no decrement that cycle
    cyc(1);
    SW = 10'h033; cyc(3);
    check("load_over_tick", LED[3:0], 4'd3);
    check("load_in_run_stays", LED[5:4], 2'b10);
    SW = 10'h023;
    wait_val(4'd2, 20, el);
    check("after_load_period", el, 4);
    wait_val(4'd0, 20, el);
    SW = 10'h003; cyc(4);

    // Load 0 then run: DONE immediately and stays there with auto-reload
    SW = 10'h010; cyc(3);
    SW = 10'h060; cyc(3);
    check("load0_done", LED[5:4], 2'b01);
    cyc(12);
    check("load0_stays_done", LED[5:0], 6'b010000);
    SW = 10'h000; cyc(4);

    // Asynchronous reset mid-run; strobe held through release gives no load
    SW = 10'h016; cyc(3);
    SW = 10'h026;
    wait_val(4'd4, 30, el);
    @(negedge init_clk);
    #2 reset = 1'b0; SW = 10'h014;
    #1 check("async_reset_led", LED, 10'd0);
    cyc(3);
    reset = 1'b1;
    cyc(8);
    check("no_load_on_release", LED, 10'd0);
    SW = 10'h004; cyc(3);
    SW = 10'h014; cyc(3);
    check("fresh_load", LED[3:0], 4'd4);
    check("fresh_load_rel", LED[9:6], 4'd4);

    // Randomized traffic against the model
    r = SW;
    for (int i = 0; i < 400; i++) begin
      r[3:0] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r[4] = ~r[4];
      r[5] = ($urandom_range(0, 9) < 8);
      r[6] = 1'($urandom_range(0, 1));
      r[9:7] = 3'($urandom_range(0, 7));
      SW = r;
      hold = $urandom_range(1, 8);
      cyc(hold);
      if ($urandom_range(0, 59) == 0) begin
        #3 reset = 1'b0;
        #1 check("rand_async_reset", LED, 10'd0);
        cyc(2);
        reset = 1'b1;
      end
    end
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
